temp_monitor_display: RTL and testbench

- Parametrised successor to the two-digit on-board temperature display.
- Polls the FPGA die temperature-sensor ADC on a configurable period and captures each reading.
- Tracks the peak reading, raises an over-threshold alarm and detects sensor timeouts.
- Drives N seven-segment digits in hex or decimal (sequential binary-to-BCD). Sits at the DE5 top level beside the temperature-sense IP.

---
 rtl/temp_monitor_display.sv | 173 +++++++++++++++++
 tb/tb_temp_monitor_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/temp_monitor_display.sv
// Polls the die temperature ADC, keeps latest/peak readings with alarm and timeout
// tracking, and renders the chosen value on seven-segment digits in hex or decimal.
module temp_monitor_display #(
  parameter int VAL_WIDTH    = 8,
  parameter int NUM_DIGITS   = 3,
  parameter int POLL_CYCLES  = 50000000,
  parameter int CLEAR_CYCLES = 1024,
  parameter int ALARM_THRESH = 85
) (
  input  logic                    clk_50mhz,
  input  logic                    rst_n,
  input  logic                    temp_valid,
  input  logic [VAL_WIDTH-1:0]    temp_val,
  input  logic                    decimal_mode,
  input  logic                    show_max,
  input  logic                    max_clear,
  output logic                    temp_en,
  output logic                    temp_clear,
  output logic [NUM_DIGITS*7-1:0] hex_d,
  output logic [NUM_DIGITS-1:0]   hex_dp,
  output logic [VAL_WIDTH-1:0]    sample,
  output logic [VAL_WIDTH-1:0]    peak,
  output logic                    alarm,
  output logic                    stale
);

  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int BW = NUM_DIGITS * 4;
  localparam int CW = $clog2(VAL_WIDTH + 1);
  localparam logic [VAL_WIDTH-1:0] THRESH = VAL_WIDTH'(ALARM_THRESH);
  localparam logic [6:0] DASH = 7'b0111111;

  typedef enum logic [1:0] {S_CLEAR, S_WAIT, S_IDLE} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer;
  logic            timer_wrap, capture, timeout;

  assign timer_wrap = (timer == TW'(POLL_CYCLES - 1));
  assign capture    = (state == S_WAIT) && temp_valid;
  assign timeout    = (state == S_WAIT) && !temp_valid && timer_wrap;

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (timer == TW'(CLEAR_CYCLES - 1)) state_next = S_WAIT;
      S_WAIT: begin
        if (capture)      state_next = S_IDLE;
        else if (timeout) state_next = S_CLEAR;
      end
      S_IDLE:  if (timer_wrap) state_next = S_CLEAR;
      default: state_next = S_CLEAR;
    endcase
  end

  // Sensor controls are registered from the next state so they line up with it.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      timer      <= '0;
      temp_en    <= 1'b0;
      temp_clear <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_wrap ? '0 : timer + 1'b1;
      temp_en    <= (state_next != S_IDLE);
      temp_clear <= (state_next != S_WAIT);
    end
  end

  logic have_cap;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sample   <= '0;
      peak     <= '0;
      alarm    <= 1'b0;
      stale    <= 1'b1;
      have_cap <= 1'b0;
    end else begin
      if (capture) begin
        sample   <= temp_val;
        alarm    <= (temp_val >= THRESH);
        stale    <= 1'b0;
        have_cap <= 1'b1;
        if (max_clear || (temp_val > peak)) peak <= temp_val;
      end else begin
        if (max_clear) peak  <= '0;
        if (timeout)   stale <= 1'b1;
      end
    end
  end

  logic dm_q, sm_q, trig_q;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      dm_q   <= 1'b0;
      sm_q   <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      dm_q   <= decimal_mode;
      sm_q   <= show_max;
      trig_q <= capture | max_clear | (decimal_mode ^ dm_q) | (show_max ^ sm_q);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return ~p;
  endfunction

  logic [VAL_WIDTH-1:0]    src, bin;
  logic [BW-1:0]           res, adj;
  logic [CW-1:0]           cnt;
  logic                    busy, done;
  logic [NUM_DIGITS*7-1:0] segs;
  logic [NUM_DIGITS-1:0]   dp_next;

  assign src = show_max ? peak : sample;

  always_comb begin
    adj     = res;
    segs    = '0;
    dp_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (res[4*i +: 4] >= 4'd5) adj[4*i +: 4] = res[4*i +: 4] + 4'd3;
      segs[7*i +: 7] = seg7(res[4*i +: 4]);
    end
    if (stale && have_cap) dp_next[0] = 1'b0;
    if (show_max)          dp_next[NUM_DIGITS-1] = 1'b0;
  end

  // A trigger always reloads, so a conversion in flight is dropped without a write.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      bin    <= '0;
      res    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hex_d  <= {NUM_DIGITS{DASH}};
      hex_dp <= '1;
    end else begin
      hex_dp <= dp_next;
      if (trig_q) begin
        bin  <= src;
        res  <= decimal_mode ? '0 : BW'(src);
        cnt  <= '0;
        busy <= decimal_mode;
        done <= !decimal_mode;
      end else if (busy) begin
        res <= {adj[BW-2:0], bin[VAL_WIDTH-1]};
        bin <= bin << 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(VAL_WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (done) begin
        done <= 1'b0;
        if (have_cap) hex_d <= segs;
      end
    end
  end

endmodule

// File: tb/tb_temp_monitor_display.sv
// Directed bench for temp_monitor_display with a timed display scoreboard.
module tb_temp_monitor_display;

  logic        clk_50mhz = 1'b0;
  logic        rst_n;
  logic        temp_valid, decimal_mode, show_max, max_clear;
  logic [7:0]  temp_val;
  logic        temp_en, temp_clear, alarm, stale;
  logic [20:0] hex_d;
  logic [2:0]  hex_dp;
  logic [7:0]  sample, peak;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;
  logic [5:0]  tmod;
  logic [52:0] exp_q[$];
  logic [52:0] mon_e;

  localparam logic [20:0] DASH3 = {3{7'h3F}};

  temp_monitor_display #(
    .VAL_WIDTH(8), .NUM_DIGITS(3), .POLL_CYCLES(64), .CLEAR_CYCLES(8), .ALARM_THRESH(85)
  ) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .temp_valid(temp_valid), .temp_val(temp_val),
    .decimal_mode(decimal_mode), .show_max(show_max), .max_clear(max_clear),
    .temp_en(temp_en), .temp_clear(temp_clear), .hex_d(hex_d), .hex_dp(hex_dp),
    .sample(sample), .peak(peak), .alarm(alarm), .stale(stale)
  );

  // clock / reset-aware timer model
  always #5 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc <= cyc + 1;
  always @(posedge clk_50mhz or negedge rst_n)
    if (!rst_n) tmod <= '0;
    else        tmod <= tmod + 6'd1;

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] sg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [20:0] dig(input int d2, input int d1, input int d0);
    return {sg(d2), sg(d1), sg(d0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: display expected one cycle before and at the due cycle
  task automatic expect_disp(input int c, input int lat, input logic [20:0] o, input logic [20:0] n);
    exp_q.push_back({32'(c + lat - 1), o});
    exp_q.push_back({32'(c + lat), n});
  endtask

  always @(negedge clk_50mhz) begin
    while (exp_q.size() > 0 && int'(exp_q[0][52:21]) <= cyc) begin
      mon_e = exp_q.pop_front();
      total++;
      if (int'(mon_e[52:21]) != cyc || hex_d !== mon_e[20:0]) begin
        bad++;
        $display("FAIL disp@%0d act=%h exp=%h (cyc %0d)", mon_e[52:21], hex_d, mon_e[20:0], cyc);
      end
    end
  end

  // driver tasks
  task automatic wait_timer(input logic [5:0] v);
    int n = 0;
    do begin
      @(negedge clk_50mhz);
      n++;
    end while (tmod != v && n < 200);
    if (tmod != v) chk("wait_timer", 32'(tmod), 32'(v));
  endtask

  task automatic do_capture(input logic [7:0] v, input logic mc, output int c);
    wait_timer(6'd20);
    temp_val = v; temp_valid = 1'b1; max_clear = mc; c = cyc;
    @(negedge clk_50mhz);
    temp_valid = 1'b0; max_clear = 1'b0;
  endtask

  task automatic cap_chk(input logic [7:0] s, input logic [7:0] p, input logic a);
    chk("sample", sample, s);
    chk("peak", peak, p);
    chk("alarm", alarm, a);
    chk("stale_cap", stale, 0);
    chk("en_idle", temp_en, 0);
    chk("clear_idle", temp_clear, 1);
  endtask

  initial begin
    rst_n = 1'b0; temp_valid = 1'b0; temp_val = '0;
    decimal_mode = 1'b1; show_max = 1'b0; max_clear = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_en", temp_en, 0);     chk("rst_clear", temp_clear, 0);
    chk("rst_sample", sample, 0);  chk("rst_peak", peak, 0);
    chk("rst_alarm", alarm, 0);    chk("rst_stale", stale, 1);
    chk("rst_hex", hex_d, DASH3);  chk("rst_dp", hex_dp, 3'b111);
    rst_n = 1'b1;

    // no valid: CLEAR 0-7, WAIT rest, wrap back to CLEAR
    for (int k = 0; k < 74; k++) begin
      @(negedge clk_50mhz);
      chk("en_poll", temp_en, 1);
      chk("clear_poll", temp_clear, 32'(tmod < 6'd8));
    end
    chk("stale_nov", stale, 1); chk("hex_nov", hex_d, DASH3); chk("dp_nov", hex_dp, 3'b111);

    // decimal capture of 57
    do_capture(8'd57, 1'b0, c0);
    cap_chk(8'd57, 8'd57, 1'b0);
    expect_disp(c0, 11, DASH3, dig(0, 5, 7));
    repeat (12) @(negedge clk_50mhz);
    temp_val = 8'd99; temp_valid = 1'b1;
    @(negedge clk_50mhz);
    temp_valid = 1'b0;
    @(negedge clk_50mhz);
    chk("valid_ignored", sample, 8'd57);

    // hex mode
    decimal_mode = 1'b0; c0 = cyc;
    expect_disp(c0, 3, dig(0, 5, 7), dig(0, 3, 9));
    repeat (5) @(negedge clk_50mhz);
    do_capture(8'd171, 1'b0, c0);
    cap_chk(8'd171, 8'd171, 1'b1);
    expect_disp(c0, 3, dig(0, 3, 9), dig(0, 10, 11));
    repeat (5) @(negedge clk_50mhz);
    do_capture(8'd57, 1'b0, c0);
    cap_chk(8'd57, 8'd171, 1'b0);
    expect_disp(c0, 3, dig(0, 10, 11), dig(0, 3, 9));
    repeat (5) @(negedge clk_50mhz);
    decimal_mode = 1'b1; c0 = cyc;
    expect_disp(c0, 11, dig(0, 3, 9), dig(0, 5, 7));
    repeat (12) @(negedge clk_50mhz);

    // peak handling and show_max
    max_clear = 1'b1; c0 = cyc;
    @(negedge clk_50mhz);
    max_clear = 1'b0;
    chk("peak_clr", peak, 0);
    expect_disp(c0, 11, dig(0, 5, 7), dig(0, 5, 7));
    repeat (12) @(negedge clk_50mhz);
    show_max = 1'b1; c0 = cyc;
    expect_disp(c0, 11, dig(0, 5, 7), dig(0, 0, 0));
    repeat (12) @(negedge clk_50mhz);
    chk("dp_max", hex_dp, 3'b011);
    do_capture(8'd90, 1'b0, c0);
    cap_chk(8'd90, 8'd90, 1'b1);
    expect_disp(c0, 11, dig(0, 0, 0), dig(0, 9, 0));
    repeat (12) @(negedge clk_50mhz);
    do_capture(8'd40, 1'b0, c0);
    cap_chk(8'd40, 8'd90, 1'b0);
    expect_disp(c0, 11, dig(0, 9, 0), dig(0, 9, 0));
    repeat (12) @(negedge clk_50mhz);
    max_clear = 1'b1; c0 = cyc;
    @(negedge clk_50mhz);
    max_clear = 1'b0;
    chk("peak_clr2", peak, 0);
    expect_disp(c0, 11, dig(0, 9, 0), dig(0, 0, 0));
    repeat (12) @(negedge clk_50mhz);
    do_capture(8'd84, 1'b1, c0);
    cap_chk(8'd84, 8'd84, 1'b0);
    expect_disp(c0, 11, dig(0, 0, 0), dig(0, 8, 4));
    repeat (12) @(negedge clk_50mhz);
    do_capture(8'd85, 1'b0, c0);
    cap_chk(8'd85, 8'd85, 1'b1);
    expect_disp(c0, 11, dig(0, 8, 4), dig(0, 8, 5));
    repeat (12) @(negedge clk_50mhz);
    show_max = 1'b0; c0 = cyc;
    expect_disp(c0, 11, dig(0, 8, 5), dig(0, 8, 5));
    repeat (12) @(negedge clk_50mhz);
    chk("dp_latest", hex_dp, 3'b111);

    // timeout keeps the value and flags stale
    do_capture(8'd200, 1'b0, c0);
    cap_chk(8'd200, 8'd200, 1'b1);
    expect_disp(c0, 11, dig(0, 8, 5), dig(2, 0, 0));
    wait_timer(6'd2);
    chk("stale_idle_wrap", stale, 0);
    wait_timer(6'd2);
    chk("stale_to", stale, 1);     chk("dp_to", hex_dp, 3'b110);
    chk("hex_to", hex_d, dig(2, 0, 0));
    chk("sample_to", sample, 8'd200);
    chk("en_to", temp_en, 1);      chk("clear_to", temp_clear, 1);
    do_capture(8'd201, 1'b0, c0);
    cap_chk(8'd201, 8'd201, 1'b1);
    expect_disp(c0, 11, dig(2, 0, 0), dig(2, 0, 1));
    repeat (12) @(negedge clk_50mhz);
    chk("dp_fresh", hex_dp, 3'b111);

    // async reset mid-WAIT and mid-conversion
    wait_timer(6'd30);
    chk("en_wait", temp_en, 1); chk("clear_wait", temp_clear, 0);
    show_max = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", temp_en, 0);     chk("arst_clear", temp_clear, 0);
    chk("arst_sample", sample, 0);  chk("arst_peak", peak, 0);
    chk("arst_alarm", alarm, 0);    chk("arst_stale", stale, 1);
    chk("arst_hex", hex_d, DASH3);  chk("arst_dp", hex_dp, 3'b111);
    repeat (2) @(negedge clk_50mhz);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_50mhz);
      chk("hex_post_rst", hex_d, DASH3);
    end
    chk("stale_post_rst", stale, 1);
    chk("dp_post_rst", hex_dp, 3'b011);
    show_max = 1'b0;
    repeat (5) @(negedge clk_50mhz);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
